load_writeback: RTL and testbench

LOAD_WRITEBACK -- requirements
Module: load_writeback

---
 rtl/load_writeback_pkg.sv | 35 +++
 rtl/load_writeback_extract.sv | 66 ++++++
 rtl/load_writeback.sv | 125 ++++++++++++
 tb/tb_load_writeback.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_writeback_pkg.sv
// Shared codes for the load writeback unit.
// Provides the register address and data word types, the load kind
// encoding, and the alignment rule applied to incoming requests.
package load_writeback_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [XLEN-1:0]   size_t;
    typedef logic [REG_AW-1:0] regaddr_t;

    typedef enum logic [2:0] {
        LK_LW  = 3'd0,
        LK_LH  = 3'd1,
        LK_LHU = 3'd2,
        LK_LB  = 3'd3,
        LK_LBU = 3'd4,
        LK_LWL = 3'd5,
        LK_LWR = 3'd6
    } load_kind_t;

    // Words must sit at offset 0 and halfwords on an even offset.
    // Bytes and the unaligned-merge loads accept any offset.
    function automatic logic is_misaligned(load_kind_t kind, logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (kind)
            LK_LW:         bad = (offset != 2'd0);
            LK_LH, LK_LHU: bad = offset[0];
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_writeback_extract.sv
// load_extract: combinational byte-lane selection, sign/zero extension
// and LWL/LWR merge for a returned big-endian memory word.
// Ports:
//   kind_i    load kind
//   offset_i  byte offset of the effective address
//   old_i     current rt value, merge source for LWL/LWR
//   mem_i     aligned big-endian word from memory
//   result_o  value to be written to the register file
module load_extract
    import load_writeback_pkg::*;
(
    input  load_kind_t  kind_i,
    input  logic [1:0]  offset_i,
    input  size_t       old_i,
    input  size_t       mem_i,
    output size_t       result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    size_t       lwl_val;
    size_t       lwr_val;

    always_comb begin
        // Big-endian: offset 0 is the most significant byte.
        byte_sel = mem_i[31:24];
        lwl_val  = mem_i;
        lwr_val  = mem_i;
        case (offset_i)
            2'd0: begin
                byte_sel = mem_i[31:24];
                lwl_val  = mem_i;
                lwr_val  = {old_i[31:8], mem_i[31:24]};
            end
            2'd1: begin
                byte_sel = mem_i[23:16];
                lwl_val  = {mem_i[23:0], old_i[7:0]};
                lwr_val  = {old_i[31:16], mem_i[31:16]};
            end
            2'd2: begin
                byte_sel = mem_i[15:8];
                lwl_val  = {mem_i[15:0], old_i[15:0]};
                lwr_val  = {old_i[31:24], mem_i[31:8]};
            end
            default: begin
                byte_sel = mem_i[7:0];
                lwl_val  = {mem_i[7:0], old_i[23:0]};
                lwr_val  = mem_i;
            end
        endcase

        half_sel = offset_i[1] ? mem_i[15:0] : mem_i[31:16];

        case (kind_i)
            LK_LW:   result_o = mem_i;
            LK_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            LK_LHU:  result_o = {16'h0000, half_sel};
            LK_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            LK_LBU:  result_o = {24'h000000, byte_sel};
            LK_LWL:  result_o = lwl_val;
            LK_LWR:  result_o = lwr_val;
            default: result_o = mem_i;
        endcase
    end

endmodule

// File: rtl/load_writeback.sv
// load_writeback: accepts one load request at a time, waits for the
// memory word, extracts the loaded value and issues a single register
// file write.
// Ports:
//   clk, reset_n_i           clock and synchronous active-low reset
//   req_*                    load request handshake and attributes
//   mem_valid_i, mem_rdata_i returned memory word
//   wb_addr_o/data/enable_o  register-file write port
//   busy_o                   a load is outstanding
//   misalign_o               one-cycle pulse on a rejected request
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | ready for a request
// S_WAIT  | request captured, waiting for the memory word
// S_WRITE | result registered, write strobe asserted
module load_writeback
    import load_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  load_kind_t  req_kind_i,
    input  regaddr_t    req_dest_i,
    input  logic [1:0]  req_offset_i,
    input  size_t       req_old_i,
    input  logic        mem_valid_i,
    input  size_t       mem_rdata_i,
    output regaddr_t    wb_addr_o,
    output size_t       wb_data_o,
    output logic        wb_enable_o,
    output logic        busy_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

    state_t     state_q;
    load_kind_t kind_q;
    regaddr_t   dest_q;
    logic [1:0] offset_q;
    size_t      old_q;
    regaddr_t   wb_addr_q;
    size_t      wb_data_q;
    logic       wb_enable_q;
    logic       ready_q;
    logic       busy_q;
    logic       misalign_q;
    size_t      result_d;

    load_extract u_extract (
        .kind_i   (kind_q),
        .offset_i (offset_q),
        .old_i    (old_q),
        .mem_i    (mem_rdata_i),
        .result_o (result_d)
    );

    // All outputs are registered; ready is held low while in reset and
    // rises on the first clock after reset is released.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            kind_q      <= LK_LW;
            dest_q      <= '0;
            offset_q    <= '0;
            old_q       <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_enable_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            wb_enable_q <= 1'b0;
            misalign_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && req_valid_i) begin
                        if (is_misaligned(req_kind_i, req_offset_i)) begin
                            misalign_q <= 1'b1;
                        end else begin
                            kind_q   <= req_kind_i;
                            dest_q   <= req_dest_i;
                            offset_q <= req_offset_i;
                            old_q    <= req_old_i;
                            ready_q  <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_valid_i) begin
                        wb_addr_q   <= dest_q;
                        wb_data_q   <= result_d;
                        // r0 is hardwired; the load completes without a strobe.
                        wb_enable_q <= (dest_q != '0);
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign wb_enable_o = wb_enable_q;
    assign busy_o      = busy_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_load_writeback.sv
module tb_load_writeback;
    import load_writeback_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n_i;
    logic       req_valid_i;
    logic       req_ready_o;
    load_kind_t req_kind_i;
    regaddr_t   req_dest_i;
    logic [1:0] req_offset_i;
    size_t      req_old_i;
    logic       mem_valid_i;
    size_t      mem_rdata_i;
    regaddr_t   wb_addr_o;
    size_t      wb_data_o;
    logic       wb_enable_o;
    logic       busy_o;
    logic       misalign_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_writeback dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_kind_i   (req_kind_i),
        .req_dest_i   (req_dest_i),
        .req_offset_i (req_offset_i),
        .req_old_i    (req_old_i),
        .mem_valid_i  (mem_valid_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_addr_o    (wb_addr_o),
        .wb_data_o    (wb_data_o),
        .wb_enable_o  (wb_enable_o),
        .busy_o       (busy_o),
        .misalign_o   (misalign_o)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load semantics written from the byte-numbering rules.
    function automatic logic [31:0] ref_load(load_kind_t k, int off, logic [31:0] old, logic [31:0] mem);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] lowmask;
        b = 8'(mem >> (8 * (3 - off)));
        h = 16'(mem >> ((off >= 2) ? 0 : 16));
        case (k)
            LK_LW:  return mem;
            LK_LB:  return 32'($signed(b));
            LK_LBU: return 32'(b);
            LK_LH:  return 32'($signed(h));
            LK_LHU: return 32'(h);
            LK_LWL: begin
                if (off == 0) return mem;
                lowmask = (32'h1 << (8 * off)) - 32'h1;
                return (mem << (8 * off)) | (old & lowmask);
            end
            LK_LWR: begin
                if (off == 3) return mem;
                lowmask = (32'h1 << (8 * (off + 1))) - 32'h1;
                return (mem >> (8 * (3 - off))) | (old & ~lowmask);
            end
            default: return mem;
        endcase
    endfunction

    // Transaction-level model: one outstanding load, results appear the
    // cycle after the memory word, ready returns the cycle after that.
    bit          model_on = 0;
    bit          m_pending, m_writing;
    logic        m_ready, m_busy, m_wen, m_mis;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    load_kind_t  p_kind;
    int          p_off;
    logic [4:0]  p_dest;
    logic [31:0] p_old;

    always @(posedge clk) begin
        if (!reset_n_i) begin
            model_on  = 1;
            m_pending = 0; m_writing = 0;
            m_ready = 0; m_busy = 0; m_wen = 0; m_mis = 0;
            m_addr = '0; m_data = '0;
        end else begin
            m_wen = 0;
            m_mis = 0;
            if (m_writing) begin
                m_writing = 0;
                m_busy    = 0;
                m_ready   = 1;
            end else if (m_pending) begin
                if (mem_valid_i) begin
                    m_addr    = p_dest;
                    m_data    = ref_load(p_kind, p_off, p_old, mem_rdata_i);
                    m_wen     = (p_dest != 0);
                    m_pending = 0;
                    m_writing = 1;
                end
            end else begin
                if (m_ready && req_valid_i) begin
                    if ((req_kind_i == LK_LW && req_offset_i != 0) ||
                        ((req_kind_i == LK_LH || req_kind_i == LK_LHU) && req_offset_i % 2 == 1)) begin
                        m_mis = 1;
                    end else begin
                        p_kind = req_kind_i; p_off = int'(req_offset_i);
                        p_dest = req_dest_i; p_old = req_old_i;
                        m_pending = 1;
                        m_ready   = 0;
                        m_busy    = 1;
                    end
                end else begin
                    m_ready = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("cyc.ready",    32'(req_ready_o), 32'(m_ready));
            chk("cyc.busy",     32'(busy_o),      32'(m_busy));
            chk("cyc.wen",      32'(wb_enable_o), 32'(m_wen));
            chk("cyc.misalign", 32'(misalign_o),  32'(m_mis));
            chk("cyc.addr",     32'(wb_addr_o),   32'(m_addr));
            chk("cyc.data",     wb_data_o,        m_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(string name, load_kind_t k, regaddr_t d, logic [1:0] off,
                           size_t old, size_t mem, int gap, logic exp_en, size_t exp_data);
        req_valid_i = 1; req_kind_i = k; req_dest_i = d; req_offset_i = off; req_old_i = old;
        cyc();
        req_valid_i = 0;
        repeat (gap) cyc();
        mem_valid_i = 1; mem_rdata_i = mem;
        cyc();
        mem_valid_i = 0; mem_rdata_i = '0;
        chk({name, ".wen"}, 32'(wb_enable_o), 32'(exp_en));
        if (exp_en) begin
            chk({name, ".addr"}, 32'(wb_addr_o), 32'(d));
            chk({name, ".data"}, wb_data_o, exp_data);
        end
        cyc();
    endtask

    initial begin
        reset_n_i = 0; req_valid_i = 0; req_kind_i = LK_LW; req_dest_i = '0;
        req_offset_i = '0; req_old_i = '0; mem_valid_i = 0; mem_rdata_i = '0;

        chk("model.lwl2", ref_load(LK_LWL, 2, 32'hAABBCCDD, 32'h11223344), 32'h3344CCDD);
        chk("model.lwr1", ref_load(LK_LWR, 1, 32'hAABBCCDD, 32'h11223344), 32'hAABB1122);
        chk("model.lb1",  ref_load(LK_LB, 1, 32'h0, 32'h1280FF00), 32'hFFFFFF80);
        chk("model.lh2",  ref_load(LK_LH, 2, 32'h0, 32'h1280FF00), 32'hFFFFFF00);

        repeat (3) cyc();
        chk("rst.ready", 32'(req_ready_o), 32'd0);
        chk("rst.busy",  32'(busy_o),      32'd0);
        chk("rst.wen",   32'(wb_enable_o), 32'd0);
        chk("rst.addr",  32'(wb_addr_o),   32'd0);
        chk("rst.data",  wb_data_o,        32'd0);
        chk("rst.mis",   32'(misalign_o),  32'd0);
        reset_n_i = 1;
        repeat (2) cyc();
        chk("idle.ready", 32'(req_ready_o), 32'd1);

        do_load("lw",    LK_LW,  5'd5,  2'd0, 32'h0,        32'hDEADBEEF, 0, 1, 32'hDEADBEEF);
        do_load("lb1",   LK_LB,  5'd6,  2'd1, 32'h0,        32'h1280FF00, 1, 1, 32'hFFFFFF80);
        do_load("lbu1",  LK_LBU, 5'd7,  2'd1, 32'h0,        32'h1280FF00, 0, 1, 32'h00000080);
        do_load("lh2",   LK_LH,  5'd8,  2'd2, 32'h0,        32'h1280FF00, 2, 1, 32'hFFFFFF00);
        do_load("lhu0",  LK_LHU, 5'd9,  2'd0, 32'h0,        32'h8001FFFF, 0, 1, 32'h00008001);
        do_load("lb3",   LK_LB,  5'd10, 2'd3, 32'h0,        32'h0000007F, 0, 1, 32'h0000007F);
        do_load("lwl2",  LK_LWL, 5'd11, 2'd2, 32'hAABBCCDD, 32'h11223344, 0, 1, 32'h3344CCDD);
        do_load("lwr1",  LK_LWR, 5'd12, 2'd1, 32'hAABBCCDD, 32'h11223344, 0, 1, 32'hAABB1122);
        do_load("lwl0",  LK_LWL, 5'd13, 2'd0, 32'hAABBCCDD, 32'h11223344, 0, 1, 32'h11223344);
        do_load("lwl3",  LK_LWL, 5'd14, 2'd3, 32'hAABBCCDD, 32'h11223344, 0, 1, 32'h44BBCCDD);
        do_load("lwr0",  LK_LWR, 5'd15, 2'd0, 32'hAABBCCDD, 32'h11223344, 0, 1, 32'hAABBCC11);
        do_load("lwr3",  LK_LWR, 5'd31, 2'd3, 32'hAABBCCDD, 32'h11223344, 1, 1, 32'h11223344);
        do_load("dest0", LK_LW,  5'd0,  2'd0, 32'h0,        32'h55555555, 0, 0, 32'h0);

        // Misaligned halfword and word: pulse, no capture.
        req_valid_i = 1; req_kind_i = LK_LH; req_dest_i = 5'd4; req_offset_i = 2'd1;
        cyc();
        req_valid_i = 0;
        chk("mis.pulse", 32'(misalign_o),  32'd1);
        chk("mis.ready", 32'(req_ready_o), 32'd1);
        chk("mis.busy",  32'(busy_o),      32'd0);
        cyc();
        chk("mis.clear", 32'(misalign_o),  32'd0);
        chk("mis.nowen", 32'(wb_enable_o), 32'd0);
        req_valid_i = 1; req_kind_i = LK_LW; req_offset_i = 2'd2;
        cyc();
        req_valid_i = 0;
        chk("mislw.pulse", 32'(misalign_o), 32'd1);
        cyc();

        // Reset while waiting aborts the load.
        req_valid_i = 1; req_kind_i = LK_LW; req_dest_i = 5'd3; req_offset_i = 2'd0;
        cyc();
        req_valid_i = 0;
        chk("abort.busy", 32'(busy_o), 32'd1);
        reset_n_i = 0;
        cyc();
        reset_n_i = 1;
        mem_valid_i = 1; mem_rdata_i = 32'h12345678;
        cyc();
        mem_valid_i = 0;
        chk("abort.busy0", 32'(busy_o),      32'd0);
        chk("abort.wen",   32'(wb_enable_o), 32'd0);
        cyc();
        chk("abort.wen2",  32'(wb_enable_o), 32'd0);
        chk("abort.ready", 32'(req_ready_o), 32'd1);

        // Stray memory word in idle is ignored.
        mem_valid_i = 1; mem_rdata_i = 32'hCAFEF00D;
        cyc();
        mem_valid_i = 0;
        chk("stray.busy", 32'(busy_o),      32'd0);
        chk("stray.wen",  32'(wb_enable_o), 32'd0);

        // Second request while waiting is ignored.
        req_valid_i = 1; req_kind_i = LK_LW; req_dest_i = 5'd7; req_offset_i = 2'd0;
        cyc();
        req_kind_i = LK_LB; req_dest_i = 5'd9; req_offset_i = 2'd3;
        cyc();
        req_valid_i = 0;
        mem_valid_i = 1; mem_rdata_i = 32'h01234567;
        cyc();
        mem_valid_i = 0;
        chk("second.wen",  32'(wb_enable_o), 32'd1);
        chk("second.addr", 32'(wb_addr_o),   32'd7);
        chk("second.data", wb_data_o,        32'h01234567);
        cyc();
        chk("second.done", 32'(wb_enable_o), 32'd0);
        cyc();
        chk("second.idle", 32'(busy_o),      32'd0);
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
